// File: rtl/ahfp_pkg.sv
// Shared definitions for the ahfp accumulation path: float32 width, zero
// constant and the accumulator controller state type.
package ahfp_pkg;

    localparam int unsigned FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        ADD,
        RES,
        DONE
    } state_t;

endpackage

// File: rtl/ahfp_acc_seq.sv
// Operand-issue / result-collection controller driving an external ahfp_add_sub:
// streams float32 operands into a running sum and returns the final sum.
module ahfp_acc_seq
    import ahfp_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [FP_W-1:0]  in_data,
    output logic             in_ready,
    output logic [FP_W-1:0]  add_a,
    output logic [FP_W-1:0]  add_b,
    input  logic [FP_W-1:0]  add_result,
    output logic             out_valid,
    output logic [FP_W-1:0]  out_data,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state;
    logic [FP_W-1:0]  acc;
    logic [CNT_W-1:0] cnt;

    // All outputs are registered alongside the state so they change only with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= FP_ZERO;
            cnt       <= '0;
            add_a     <= FP_ZERO;
            add_b     <= FP_ZERO;
            out_data  <= FP_ZERO;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        acc  <= FP_ZERO;
                        if (len == '0) begin
                            out_data  <= FP_ZERO;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt      <= len;
                            in_ready <= 1'b1;
                            state    <= WAIT_IN;
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid && in_ready) begin
                        add_a    <= acc;
                        add_b    <= in_data;
                        cnt      <= cnt - 1'b1;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    state <= RES;
                end
                RES: begin
                    // The adder result is only meaningful here, one edge after issue.
                    acc <= add_result;
                    if (cnt == '0) begin
                        out_data  <= add_result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= WAIT_IN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
